// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends start bit, 2-bit port, 4-bit length and N payload bits,
// one bit per clkEn strobe, and shows the remaining payload count on a seven-segment display.
module serial_frame_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [1:0]        port,
    input  logic [3:0]        len,
    input  logic [DATA_W-1:0] data,
    output logic              SerOut,
    output logic              busy,
    output logic              Done,
    output logic [6:0]        SSD_Out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_STRT = 3'd2;
    localparam logic [2:0] S_PORT = 3'd3;
    localparam logic [2:0] S_LEN  = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        port_q, port_d;
    logic [3:0]        len_q, len_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        rem_q, rem_d;
    logic              serout_q, serout_d;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        len_d   = len_q;
        shift_d = shift_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    port_d  = port;
                    len_d   = len;
                    shift_d = data;
                    rem_d   = len;
                    cnt_d   = 2'd0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (clkEn) state_d = S_STRT;
            end
            S_STRT: begin
                if (clkEn) begin
                    state_d = S_PORT;
                    cnt_d   = 2'd1;
                end
            end
            S_PORT: begin
                if (clkEn) begin
                    if (cnt_q == 2'd0) begin
                        state_d = S_LEN;
                        cnt_d   = 2'd3;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            S_LEN: begin
                if (clkEn) begin
                    if (cnt_q == 2'd0) begin
                        state_d = (len_q != 4'd0) ? S_DATA : S_DONE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (clkEn) begin
                    shift_d = shift_q >> 1;
                    rem_d   = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line value is computed from the next state so the register holds the bit of the upcoming cycle.
        case (state_d)
            S_STRT:  serout_d = 1'b0;
            S_PORT:  serout_d = port_d[cnt_d[0]];
            S_LEN:   serout_d = len_d[cnt_d];
            S_DATA:  serout_d = shift_d[0];
            default: serout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            port_q   <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
            serout_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            serout_q <= serout_d;
        end
    end

    assign SerOut = serout_q;
    assign busy   = (state_q != S_IDLE);
    assign Done   = (state_q == S_DONE);

    // rem_q is zero in IDLE and DONE, so the display needs no state qualification.
    always_comb begin
        SSD_Out = 7'b0111111;
        case (rem_q)
            4'h0: SSD_Out = 7'b0111111;
            4'h1: SSD_Out = 7'b0000110;
            4'h2: SSD_Out = 7'b1011011;
            4'h3: SSD_Out = 7'b1001111;
            4'h4: SSD_Out = 7'b1100110;
            4'h5: SSD_Out = 7'b1101101;
            4'h6: SSD_Out = 7'b1111101;
            4'h7: SSD_Out = 7'b0000111;
            4'h8: SSD_Out = 7'b1111111;
            4'h9: SSD_Out = 7'b1101111;
            4'hA: SSD_Out = 7'b1110111;
            4'hB: SSD_Out = 7'b1111100;
            4'hC: SSD_Out = 7'b0111001;
            4'hD: SSD_Out = 7'b1011110;
            4'hE: SSD_Out = 7'b1111001;
            4'hF: SSD_Out = 7'b1110001;
            default: SSD_Out = 7'b0111111;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: driver pushes the expected frame when it requests one,
// a negedge monitor collects each bit period and compares whole frames on every Done pulse.
module tb_serial_frame_tx;

    typedef struct {
        logic [23:0] bits;
        int          nbits;
        logic [3:0]  len;
        int          cycles;
        bit          chk_gap;
    } exp_t;

    localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [1:0]  port_v;
    logic [3:0]  len_v;
    logic [15:0] data_v;
    logic        ser_out;
    logic        busy;
    logic        done;
    logic [6:0]  ssd;

    int   total;
    int   bad;
    int   mode;
    exp_t exp_q [$];
    logic [6:0] ssd_q [$];

    serial_frame_tx #(.DATA_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .clkEn  (clk_en),
        .start  (start),
        .port   (port_v),
        .len    (len_v),
        .data   (data_v),
        .SerOut (ser_out),
        .busy   (busy),
        .Done   (done),
        .SSD_Out(ssd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // clkEn pattern: 0 = always high, 1 = every 4th clk, 2 = random
    initial begin
        int div;
        div    = 0;
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       clk_en = 1'b1;
                1:       clk_en = (div == 3);
                default: clk_en = 1'($urandom_range(0, 1));
            endcase
            div = (div + 1) % 4;
        end
    end

    // Reference frame: ARM idle period, start 0, port msb-first, len msb-first, data lsb-first.
    task automatic issue(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d, input bit gap);
        exp_t e;
        e.bits    = '0;
        e.bits[0] = 1'b1;
        e.bits[1] = 1'b0;
        e.bits[2] = p[1];
        e.bits[3] = p[0];
        for (int i = 0; i < 4; i++) e.bits[4+i] = l[3-i];
        for (int k = 0; k < int'(l); k++) e.bits[8+k] = d[k];
        e.nbits   = 8 + int'(l);
        e.len     = l;
        e.cycles  = (mode == 0) ? 9 + int'(l) : 0;
        e.chk_gap = gap;
        exp_q.push_back(e);
        port_v = p;
        len_v  = l;
        data_v = d;
        start  = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while (busy && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic run_frame(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
        bit seen;
        seen = 0;
        wait_idle();
        issue(p, l, d, 0);
        for (int k = 0; k < 500 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
            end else if (busy) begin
                start  = 1'($urandom_range(0, 1));
                port_v = 2'($urandom);
                len_v  = 4'($urandom);
                data_v = 16'($urandom);
            end
        end
        start = 1'b0;
        if (!seen) check("frame_timeout", seen, 1);
    endtask

    task automatic run_b2b(input int n);
        int  cnt;
        bit  fin;
        cnt = 1;
        fin = 0;
        wait_idle();
        issue(2'($urandom), 4'($urandom), 16'($urandom), 0);
        for (int k = 0; k < 500 * n && !fin; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (cnt < n) begin
                    issue(2'($urandom), 4'($urandom), 16'($urandom), 1);
                    cnt++;
                end else begin
                    fin = 1;
                end
            end else if (busy) begin
                port_v = 2'($urandom);
                len_v  = 4'($urandom);
                data_v = 16'($urandom);
            end
        end
        start = 1'b0;
        if (!fin) check("b2b_timeout", fin, 1);
    endtask

    task automatic run_abort();
        wait_idle();
        issue(2'b10, 4'd6, 16'($urandom), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_state", {ser_out, busy, done, ssd}, {1'b1, 1'b0, 1'b0, 7'h3F});
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: one sample per bit period (clkEn high while busy), whole-frame compare at Done.
    initial begin
        logic [23:0] got;
        int          n;
        int          cyc;
        int          idle;
        int          mism;
        int          v;
        bit          after_done;
        logic        prev_busy;
        exp_t        e;
        got = '0; n = 0; cyc = 0; idle = 100; after_done = 0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (after_done) begin
                check("idle_after_done", {busy, done, ser_out}, 3'b001);
                after_done = 0;
            end
            if (busy && !prev_busy && exp_q.size() > 0 && exp_q[0].chk_gap)
                check("idle_gap", idle, 1);
            if (!busy) begin
                got = '0; n = 0; cyc = 0;
                ssd_q.delete();
                idle++;
            end else begin
                cyc++;
                if (done) begin
                    check("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_nbits", n, e.nbits);
                        check("frame_bits", got, e.bits);
                        mism = 0;
                        foreach (ssd_q[i]) begin
                            v = (i < 8) ? int'(e.len) : int'(e.len) - (i - 8);
                            if (ssd_q[i] !== SEG[v & 15]) mism++;
                        end
                        check("ssd_mismatches", mism, 0);
                        check("done_serout", ser_out, 1);
                        if (e.cycles > 0) check("frame_cycles", cyc, e.cycles);
                    end
                    idle       = 0;
                    after_done = 1;
                    got        = '0;
                    n          = 0;
                    ssd_q.delete();
                end else if (clk_en) begin
                    if (n < 24) got[n] = ser_out;
                    ssd_q.push_back(ssd);
                    n++;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        total  = 0;
        bad    = 0;
        mode   = 0;
        rst    = 1'b0;
        start  = 1'b0;
        port_v = '0;
        len_v  = '0;
        data_v = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ser_out, busy, done, ssd}, {1'b1, 1'b0, 1'b0, 7'h3F});
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_without_start", {busy, ser_out}, 2'b01);

        mode = 1;
        run_frame(2'd2, 4'd3, 16'h0005);
        mode = 0;
        run_frame(2'd0, 4'd0, 16'hABCD);
        run_frame(2'd3, 4'd15, 16'hFFFF);

        run_abort();
        run_frame(2'd1, 4'd9, 16'($urandom));

        for (int i = 0; i < 30; i++) begin
            mode = $urandom_range(0, 2);
            run_frame(2'($urandom), 4'($urandom), 16'($urandom));
        end

        mode = 0;
        run_b2b(4);
        mode = 2;
        run_b2b(3);

        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
